// File: rtl/iir_seq_pkg.sv
// Shared types and constants for the IIR stream sequencer.
// State encoding, default sample width and Q20 test-tone values.
package iir_seq_pkg;

  localparam int DATA_W_DEF = 32;

  // Q20 fixed point: 1.0 = 2^20
  localparam int Q20_ONE = 1048576;

  // 6 kHz tone sampled at 48 kHz: sin(pi/4), sin(pi/2)
  localparam int TONE_A = 741455;
  localparam int TONE_B = 1048576;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    RUN,
    DRAIN
  } state_t;

endpackage

// File: rtl/valid_delay_line.sv
// DEPTH-stage 1-bit shift register with synchronous clear.
// Ports: clk, reset (sync, active-high), din, dout (din after DEPTH edges).
module valid_delay_line #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else begin
      sr <= DEPTH'({sr, din});
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/iir_stream_sequencer.sv
// Sequencer for the pipelined_iir datapath: flush, stream, drain.
// Ports: clk/reset, start/stop pulses, s_* source handshake,
//   iir_reset/iir_x/iir_y filter side, m_valid/m_data result,
//   busy status and saturating underrun_cnt.
module iir_stream_sequencer
  import iir_seq_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int LATENCY   = 4,
  parameter int FLUSH_LEN = 16,
  parameter int UCNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              iir_reset,
  output logic [DATA_W-1:0] iir_x,
  input  logic [DATA_W-1:0] iir_y,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic [UCNT_W-1:0] underrun_cnt
);

  localparam int CNT_MAX =
    (FLUSH_LEN > LATENCY) ? FLUSH_LEN : LATENCY + 1;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] FLUSH_CNT =
    CNT_W'(FLUSH_LEN - 1);
  localparam logic [CNT_W-1:0] DRAIN_CNT =
    CNT_W'(LATENCY);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             x_tag;
  logic             tag_out;

  assign s_ready = (state == RUN);

  // x_tag rides alongside iir_x, so a LATENCY-deep
  // delay lines it up with the matching iir_y.
  valid_delay_line #(
    .DEPTH (LATENCY)
  ) u_tags (
    .clk   (clk),
    .reset (reset),
    .din   (x_tag),
    .dout  (tag_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      iir_reset    <= 1'b1;
      iir_x        <= '0;
      x_tag        <= 1'b0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      busy         <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      iir_x   <= '0;
      x_tag   <= 1'b0;
      m_valid <= tag_out;
      m_data  <= iir_y;
      unique case (state)
        IDLE: begin
          if (start && !stop) begin
            state        <= FLUSH;
            cnt          <= FLUSH_CNT;
            underrun_cnt <= '0;
            busy         <= 1'b1;
            iir_reset    <= 1'b0;
          end
        end
        FLUSH: begin
          if (stop) begin
            state     <= IDLE;
            busy      <= 1'b0;
            iir_reset <= 1'b1;
          end else if (cnt == '0) begin
            state <= RUN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RUN: begin
          if (s_valid) begin
            iir_x <= s_data;
            x_tag <= 1'b1;
          end else if (underrun_cnt != '1) begin
            underrun_cnt <= underrun_cnt + 1'b1;
          end
          // the sample offered with stop is still taken
          if (stop) begin
            state <= DRAIN;
            cnt   <= DRAIN_CNT;
          end
        end
        DRAIN: begin
          if (cnt == '0) begin
            state     <= IDLE;
            busy      <= 1'b0;
            iir_reset <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      endcase
    end
  end

endmodule
